// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation mode
// encoding and the slice-width helper used to size each pipeline stage.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? width / stages : 0;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple adder made of full_adder cells; also reports the
// signed-overflow condition seen at its top bit.
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          ovf
);

  // Each bit keeps its own carry nets so the chain is a series of scalars.
  for (genvar i = 0; i < SW; i++) begin : g_bit
    logic c_in;
    logic c_out;
    if (i == 0) begin : g_lsb
      assign c_in = ci;
    end else begin : g_chain
      assign c_in = g_bit[i-1].c_out;
    end
    full_adder u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c_in),
      .s (s[i]),
      .co(c_out)
    );
  end

  assign co  = g_bit[SW-1].c_out;
  assign ovf = (a[SW-1] == b[SW-1]) && (s[SW-1] != a[SW-1]);

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of every ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: STAGES ripple slices with a registered carry
// between them, valid/ready on both sides, one result per cycle.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: STAGES=%0d must divide WIDTH=%0d", STAGES, WIDTH);
  end

  logic              advance;
  logic [WIDTH-1:0]  a_pipe   [STAGES];
  logic [WIDTH-1:0]  b_pipe   [STAGES];
  logic [WIDTH-1:0]  sum_pipe [STAGES+1];
  logic [STAGES:0]   carry_pipe;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES-1:0] ovf_c;
  logic              ovf_q;
  logic              unused_ok;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign advance  = !vld_pipe[STAGES] || out_ready;
  assign in_ready = advance;

  assign a_pipe[0]     = in_a;
  assign b_pipe[0]     = (in_sub == MODE_SUB) ? ~in_b : in_b;
  assign carry_pipe[0] = (in_sub == MODE_SUB) ? ~in_cin : in_cin;
  assign vld_pipe[0]   = in_valid;
  assign sum_pipe[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             vld_r;

    adder_slice #(.SW(SW)) u_slice (
      .a  (a_pipe[k][k*SW +: SW]),
      .b  (b_pipe[k][k*SW +: SW]),
      .ci (carry_pipe[k]),
      .s  (slice_s),
      .co (slice_co),
      .ovf(ovf_c[k])
    );

    always_comb begin
      sum_next = sum_pipe[k];
      sum_next[k*SW +: SW] = slice_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r   <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (advance) begin
        vld_r   <= vld_pipe[k];
        carry_r <= slice_co;
        sum_r   <= sum_next;
      end
    end

    assign vld_pipe[k+1]   = vld_r;
    assign carry_pipe[k+1] = carry_r;
    assign sum_pipe[k+1]   = sum_r;

    // Operands ride along so the upper slices meet their carry one stage later.
    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance) begin
          a_r <= a_pipe[k];
          b_r <= b_pipe[k];
        end
      end

      assign a_pipe[k+1] = a_r;
      assign b_pipe[k+1] = b_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_c[STAGES-1];
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_sum   = sum_pipe[STAGES];
  assign out_co    = carry_pipe[STAGES];
  assign out_ovf   = ovf_q;

  // Only the final stage's overflow and each operand's top slice matter downstream.
  assign unused_ok = ^{a_pipe[STAGES-1], b_pipe[STAGES-1], ovf_c};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 4-, 1- and 16-stage instances share stimulus and
// each is scored against a plain-arithmetic reference model.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  localparam int WIDTH = 16;
  localparam int NDUT  = 3;

  typedef struct packed {
    logic [17:0] res;
    int          cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic                in_cin;
  logic                in_sub;
  logic                out_ready;
  logic [NDUT-1:0]     in_ready_v;
  logic [NDUT-1:0]     out_valid_v;
  logic [NDUT-1:0]     out_co_v;
  logic [NDUT-1:0]     out_ovf_v;
  logic [WIDTH-1:0]    out_sum_v [NDUT];

  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  bit   lat_check;
  exp_t exp_q [NDUT][$];

  int          sent;
  int          iter;
  bit          new_op;
  bit          stall_prev;
  logic [18:0] snap;
  logic [18:0] now_v;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_sum(out_sum_v[0]),
    .out_co(out_co_v[0]), .out_ovf(out_ovf_v[0])
  );

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_sum(out_sum_v[1]),
    .out_co(out_co_v[1]), .out_ovf(out_ovf_v[1])
  );

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_sum(out_sum_v[2]),
    .out_co(out_co_v[2]), .out_ovf(out_ovf_v[2])
  );

  function automatic int stages_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
  endfunction

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
    int ua, ub, sa, sb, ci, r, sr;
    logic [15:0] sum;
    logic co, ovf;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = cin ? 1 : 0;
    if (sub == MODE_ADD) begin
      r  = ua + ub + ci;
      co = (r > 65535);
      sr = sa + sb + ci;
    end else begin
      r  = ua - ub - ci;
      co = (r >= 0);
      sr = sa - sb - ci;
    end
    sum = r[15:0];
    ovf = (sr > 32767) || (sr < -32768);
    return {ovf, co, sum};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_drained(input string tag);
    for (int d = 0; d < NDUT; d++)
      checkOutput($sformatf("%s_dut%0d_pending", tag, d), exp_q[d].size(), 0);
  endtask

  // Scoreboard: handshakes are sampled mid-low-phase, ahead of the edge that takes them.
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        exp_t e;
        exp_t n;
        if (out_valid_v[d] && out_ready) begin
          if (exp_q[d].size() == 0) begin
            checkOutput($sformatf("dut%0d_unexpected_result", d), 1, 0);
          end else begin
            e = exp_q[d].pop_front();
            checkOutput($sformatf("dut%0d_result", d),
                        {14'd0, out_ovf_v[d], out_co_v[d], out_sum_v[d]}, {14'd0, e.res});
            if (lat_check)
              checkOutput($sformatf("dut%0d_latency", d), cycle - e.cyc, stages_of(d));
          end
        end
        if (in_valid && in_ready_v[d]) begin
          n.res = ref_model(in_a, in_b, in_cin, in_sub);
          n.cyc = cycle;
          exp_q[d].push_back(n);
        end
      end
    end
  end

  always @(negedge rst_n) begin
    for (int d = 0; d < NDUT; d++) exp_q[d].delete();
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = MODE_ADD;
    out_ready = 1'b1;
    lat_check = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("reset_dut%0d_valid", d), out_valid_v[d], 0);
      checkOutput($sformatf("reset_dut%0d_sum", d), out_sum_v[d], 0);
      checkOutput($sformatf("reset_dut%0d_co", d), out_co_v[d], 0);
      checkOutput($sformatf("reset_dut%0d_ovf", d), out_ovf_v[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic corners, back to back with the consumer always ready.
    applyStimulus(16'h1234, 16'h4321, 1'b0, MODE_ADD);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, MODE_ADD);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, MODE_ADD);
    applyStimulus(16'h0005, 16'h0007, 1'b0, MODE_SUB);
    applyStimulus(16'h8000, 16'h0001, 1'b0, MODE_SUB);
    applyStimulus(16'hFFFE, 16'h0000, 1'b1, MODE_ADD);
    applyStimulus(16'h0000, 16'h0000, 1'b1, MODE_SUB);
    applyStimulus(16'h8000, 16'h8000, 1'b0, MODE_ADD);
    idle_cycles(24);
    check_drained("directed");

    // Eight-op stream with a three-cycle consumer stall in the middle.
    lat_check  = 1'b0;
    sent       = 0;
    iter       = 0;
    new_op     = 1'b1;
    stall_prev = 1'b0;
    snap       = '0;
    while (sent < 8 && iter < 100) begin
      @(negedge clk);
      if (new_op) begin
        in_a   = 16'($urandom);
        in_b   = 16'($urandom);
        in_cin = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
      end
      in_valid  = 1'b1;
      out_ready = !(iter >= 5 && iter <= 7);
      #1;
      now_v = {out_valid_v[0], out_ovf_v[0], out_co_v[0], out_sum_v[0]};
      if (!out_ready) begin
        checkOutput("stall_out_valid", out_valid_v[0], 1);
        checkOutput("stall_in_ready", in_ready_v[0], 0);
        if (stall_prev) checkOutput("stall_outputs_frozen", now_v, snap);
        snap = now_v;
      end
      stall_prev = !out_ready;
      new_op     = in_ready_v[0];
      if (in_ready_v[0]) sent++;
      iter++;
    end
    if (sent < 8) checkOutput("stream_timeout", sent, 8);
    out_ready = 1'b1;
    idle_cycles(30);
    check_drained("stream");

    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_cin    = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1'b1;
    idle_cycles(30);
    check_drained("random");

    // Reset pulse between edges with three operations in flight.
    lat_check = 1'b1;
    applyStimulus(16'h1111, 16'h2222, 1'b0, MODE_ADD);
    applyStimulus(16'h3333, 16'h0444, 1'b1, MODE_SUB);
    applyStimulus(16'hABCD, 16'h1357, 1'b0, MODE_ADD);
    idle_cycles(1);
    @(negedge clk);
    #1;
    checkOutput("pre_reset_dut4_valid", out_valid_v[0], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("midreset_dut%0d_valid", d), out_valid_v[d], 0);
      checkOutput($sformatf("midreset_dut%0d_sum", d), out_sum_v[d], 0);
      checkOutput($sformatf("midreset_dut%0d_co", d), out_co_v[d], 0);
      checkOutput($sformatf("midreset_dut%0d_ovf", d), out_ovf_v[d], 0);
    end
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++)
        checkOutput($sformatf("post_reset_dut%0d_c%0d_valid", d, c), out_valid_v[d], 0);
    end
    check_drained("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit; the next generation of the team's single-bit half/full adder cells.
- Splits a WIDTH-bit operation into STAGES slices. Each slice's carry is registered into the next stage, giving one result per cycle at STAGES-cycle latency.
- Valid/ready handshake on both sides for use inside datapaths with backpressure.
- Reports carry-out and signed overflow alongside the result.

Parameters:
- WIDTH, 16, operand/result width in bits.
- STAGES, 4, number of pipeline stages. Must divide WIDTH exactly. 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid && in_ready.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in for add; borrow-in for sub.
- in_sub  input  1  0 = A+B+cin; 1 = A-B-borrow.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result when out_valid && out_ready.
- out_sum  output  WIDTH  result.
- out_co  output  1  carry-out. For sub, 1 = no borrow.
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: asynchronous, active-low. While rst_n = 0 and on release:
  - all stage valid bits = 0, out_valid = 0;
  - out_sum = 0, out_co = 0, out_ovf = 0;
  - all slice data and carry registers = 0.
- Slice width: SW = WIDTH/STAGES. Non-integer SW or STAGES > WIDTH must cause an elaboration error ($error in a generate check).
- Arithmetic: B' = in_sub ? ~in_b : in_b. Carry-in c0 = in_sub ? ~in_cin : in_cin. Result = A + B' + c0, modulo 2^WIDTH.
- out_co = carry out of bit WIDTH-1.
- out_ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]).
- Stage k (0..STAGES-1):
  - adds slice k of A and B' plus the registered carry from stage k-1 (c0 for k=0);
  - registers the SW-bit partial sum and the carry.
- Operand skew: A/B' slices for stage k travel through k registers, so they meet their carry. Already-computed lower slices are carried forward alongside so the full word is aligned at the final stage.
- Advance rule:
  - advance = !out_valid || out_ready;
  - the whole pipeline shifts only when advance = 1;
  - in_ready = advance (combinational from out_valid/out_ready only, never from in_valid).
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES, absent stalls. Throughput is one operation per cycle.
- Bubbles: a stage valid bit of 0 propagates as a bubble. Data registers may update with don't-care values when invalid, but out_sum/out_co/out_ovf must only change on an advancing edge.
- Stall (out_valid && !out_ready): all stage registers and outputs hold exactly. in_ready = 0. No beat is lost or duplicated.
- Simultaneous accept and drain on the same edge is legal and sustains full rate.
- Bubble collapse is not required; a stalled pipeline with internal bubbles stays stalled as a whole.
- Reset mid-operation: all in-flight beats are discarded. out_valid drops asynchronously. No stale result emerges after rst_n rises.
- STAGES = 1: a single registered full-width adder with latency 1; same handshake rules.
- Order is strictly preserved.

Decomposition:
- Package addsub_pkg:
  - function slice_width(WIDTH, STAGES);
  - localparam enumerating mode encoding (MODE_ADD = 1'b0, MODE_SUB = 1'b1).
- Sub-module adder_slice:
  - parameter SW; purely combinational SW-bit ripple adder built from the team's full_adder cells;
  - ports a, b, ci, s, co;
  - plus the MSB operand bits needed for the final-stage overflow computation.
- Top level generates STAGES instances of adder_slice plus skew/valid registers.

Test Plan (WIDTH=16, STAGES=4, out_ready=1 unless stated):
1. Add 0x1234 + 0x4321, cin=0, accepted at edge N -> out_valid=1 after edge N+4; sum=0x5555, co=0, ovf=0.
2. Add 0xFFFF + 0x0001 (carry ripples through all 4 slices) -> sum=0x0000, co=1, ovf=0. Then 0x7FFF + 0x0001 -> sum=0x8000, co=0, ovf=1.
3. Sub 0x0005 - 0x0007, borrow=0 -> sum=0xFFFE, co=0, ovf=0. Then sub 0x8000 - 0x0001 -> sum=0x7FFF, co=1, ovf=1.
4. Back-to-back stream of 8 random ops, then out_ready=0 for 3 cycles mid-stream:
   - in_ready=0 and outputs frozen during the stall;
   - all 8 results emerge in order, matching the reference model, none lost or duplicated.
5. Three ops in flight, pulse rst_n low between edges -> out_valid=0 immediately, outputs=0; after release no result appears for 6 cycles.
6. Re-run scenarios 1-3 with STAGES=1 (latency 1) and STAGES=16 (latency 16). Confirm WIDTH=16, STAGES=3 fails elaboration.
